// File: rtl/roi_pool_core_if.sv
// Pixel-stream / CNN-buffer bundle for roi_pool_core.
// master: pixel source + config; slave: the pooling core.
interface roi_pool_core_if #(
   parameter int PIX_W     = 4,
   parameter int OUT_PIX_W = 8,
   parameter int AW        = 10
);
   logic [PIX_W-1:0]     pix_in;
   logic                 pix_valid;
   logic                 sof;
   logic                 enable;
   logic [1:0]           mode;
   logic [OUT_PIX_W-1:0] thresh;
   logic [9:0]           roi_x;
   logic [9:0]           roi_y;
   logic [AW-1:0]        out_addr;
   logic [OUT_PIX_W-1:0] out_data;
   logic                 out_we;
   logic                 frame_done;
   logic                 busy;
   logic                 cfg_err;

   modport master (
      output pix_in, pix_valid, sof, enable,
      output mode, thresh, roi_x, roi_y,
      input  out_addr, out_data, out_we,
      input  frame_done, busy, cfg_err
   );

   modport slave (
      input  pix_in, pix_valid, sof, enable,
      input  mode, thresh, roi_x, roi_y,
      output out_addr, out_data, out_we,
      output frame_done, busy, cfg_err
   );
endinterface

// File: rtl/roi_pool_core.sv
// ROI block-pooling downsampler: camera pixel stream -> OUT_W x OUT_H CNN image.
// Ports: clk25, rst_n (async, active-low), io (slave: pixels/config in, buffer writes/status out).
module roi_pool_core #(
   parameter int WIDTH     = 640,
   parameter int HEIGHT    = 480,
   parameter int PIX_W     = 4,
   parameter int OUT_PIX_W = 8,
   parameter int BLK_W     = 8,
   parameter int BLK_H     = 8,
   parameter int OUT_W     = 28,
   parameter int OUT_H     = 28
) (
   input logic             clk25,
   input logic             rst_n,
   roi_pool_core_if.slave  io
);
   localparam int N     = BLK_W * BLK_H;
   localparam int LBW   = $clog2(BLK_W);
   localparam int LBH   = $clog2(BLK_H);
   localparam int LN    = LBW + LBH;
   localparam int ACC_W = PIX_W + LN;
   localparam int AW    = $clog2(OUT_W * OUT_H);
   localparam int REP   = OUT_PIX_W / PIX_W;
   localparam int BXW   = $clog2(OUT_W);
   localparam int BYW   = $clog2(OUT_H);
   localparam int CW    = 12;
   localparam int LAST  = OUT_W * OUT_H - 1;

   localparam logic [CW-1:0] ROI_W = CW'(BLK_W * OUT_W);
   localparam logic [CW-1:0] ROI_H = CW'(BLK_H * OUT_H);
   localparam logic [CW-1:0] FR_W  = CW'(WIDTH);
   localparam logic [CW-1:0] FR_H  = CW'(HEIGHT);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        hcnt_q, hcnt_d;
   logic [CW-1:0]        vcnt_q, vcnt_d;
   logic [9:0]           roi_x_q, roi_x_d;
   logic [9:0]           roi_y_q, roi_y_d;
   logic [1:0]           mode_q, mode_d;
   logic [OUT_PIX_W-1:0] thresh_q, thresh_d;
   logic [ACC_W-1:0]     acc_q [OUT_W];
   logic [ACC_W-1:0]     acc_d [OUT_W];
   logic [AW-1:0]        out_addr_q, out_addr_d;
   logic [OUT_PIX_W-1:0] out_data_q, out_data_d;
   logic                 out_we_q, out_we_d;
   logic                 frame_done_q, frame_done_d;
   logic                 busy_q, busy_d;
   logic                 cfg_err_q, cfg_err_d;

   logic                 sof_v, fit, run, hit, first, last;
   logic [CW-1:0]        ch, cv, rx, ry, dx, dy;
   logic [1:0]           md;
   logic [OUT_PIX_W-1:0] th;
   logic [BXW-1:0]       bx;
   logic [BYW-1:0]       by;
   logic [AW-1:0]        blk_addr;
   logic [ACC_W-1:0]     pix_ext, cur, nxt, rnd;
   logic [PIX_W-1:0]     avg_a, max_a;
   logic [OUT_PIX_W-1:0] avg_rep, res;

   always_comb begin
      state_d      = state_q;
      hcnt_d       = hcnt_q;
      vcnt_d       = vcnt_q;
      roi_x_d      = roi_x_q;
      roi_y_d      = roi_y_q;
      mode_d       = mode_q;
      thresh_d     = thresh_q;
      acc_d        = acc_q;
      out_addr_d   = out_addr_q;
      out_data_d   = out_data_q;
      out_we_d     = 1'b0;
      frame_done_d = 1'b0;
      busy_d       = busy_q;
      cfg_err_d    = cfg_err_q;

      // The sof pixel is (0,0) and already uses the config presented with it.
      sof_v = io.sof & io.pix_valid;
      fit   = (CW'(io.roi_x) + ROI_W <= FR_W) &&
              (CW'(io.roi_y) + ROI_H <= FR_H);
      rx    = sof_v ? CW'(io.roi_x) : CW'(roi_x_q);
      ry    = sof_v ? CW'(io.roi_y) : CW'(roi_y_q);
      md    = sof_v ? io.mode : mode_q;
      th    = sof_v ? io.thresh : thresh_q;
      ch    = sof_v ? '0 : hcnt_q;
      cv    = sof_v ? '0 : vcnt_q;
      run   = sof_v ? (io.enable & fit) : (state_q == RUN);

      dx    = ch - rx;
      dy    = cv - ry;
      hit   = io.pix_valid && run && (cv < FR_H) &&
              (ch >= rx) && (dx < ROI_W) &&
              (cv >= ry) && (dy < ROI_H);
      bx    = BXW'(dx >> LBW);
      by    = BYW'(dy >> LBH);
      first = (dx[LBW-1:0] == '0) && (dy[LBH-1:0] == '0);
      last  = (&dx[LBW-1:0]) && (&dy[LBH-1:0]);
      blk_addr = AW'(32'(by) * OUT_W + 32'(bx));

      pix_ext = ACC_W'(io.pix_in);
      cur     = acc_q[bx];
      if (first)
         nxt = pix_ext;
      else if (md == 2'b01)
         nxt = (pix_ext > cur) ? pix_ext : cur;
      else
         nxt = cur + pix_ext;

      // Round-to-nearest; the sum+N/2 cannot overflow ACC_W.
      rnd     = nxt + ACC_W'(N / 2);
      avg_a   = PIX_W'(rnd >> LN);
      max_a   = PIX_W'(nxt);
      avg_rep = {REP{avg_a}};

      case (md)
         2'b01:   res = {REP{max_a}};
         2'b10:   res = (avg_rep >= th) ? '1 : '0;
         default: res = avg_rep;
      endcase

      if (state_q == DONE) begin
         frame_done_d = 1'b1;
         state_d      = IDLE;
         busy_d       = 1'b0;
      end

      // A sof in any state restarts (or aborts) with fresh config.
      if (sof_v) begin
         roi_x_d   = io.roi_x;
         roi_y_d   = io.roi_y;
         mode_d    = io.mode;
         thresh_d  = io.thresh;
         cfg_err_d = io.enable & ~fit;
         state_d   = run ? RUN : IDLE;
         busy_d    = run;
      end

      if (hit) begin
         acc_d[bx] = nxt;
         if (last) begin
            out_we_d   = 1'b1;
            out_addr_d = blk_addr;
            out_data_d = res;
            if (blk_addr == AW'(LAST))
               state_d = DONE;
         end
      end

      // Counters freeze once past the last row until the next sof.
      if (io.pix_valid && (cv < FR_H)) begin
         if (ch == FR_W - 1'b1) begin
            hcnt_d = '0;
            vcnt_d = cv + 1'b1;
         end else begin
            hcnt_d = ch + 1'b1;
            vcnt_d = cv;
         end
      end
   end

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         hcnt_q       <= '0;
         vcnt_q       <= '0;
         roi_x_q      <= '0;
         roi_y_q      <= '0;
         mode_q       <= '0;
         thresh_q     <= '0;
         for (int i = 0; i < OUT_W; i++)
            acc_q[i]  <= '0;
         out_addr_q   <= '0;
         out_data_q   <= '0;
         out_we_q     <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         hcnt_q       <= hcnt_d;
         vcnt_q       <= vcnt_d;
         roi_x_q      <= roi_x_d;
         roi_y_q      <= roi_y_d;
         mode_q       <= mode_d;
         thresh_q     <= thresh_d;
         acc_q        <= acc_d;
         out_addr_q   <= out_addr_d;
         out_data_q   <= out_data_d;
         out_we_q     <= out_we_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
         cfg_err_q    <= cfg_err_d;
      end
   end

   assign io.out_addr   = out_addr_q;
   assign io.out_data   = out_data_q;
   assign io.out_we     = out_we_q;
   assign io.frame_done = frame_done_q;
   assign io.busy       = busy_q;
   assign io.cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_roi_pool_core.sv
// Directed bench for roi_pool_core on a reduced 64x40 frame, 8x8 blocks, 4x3 output.
// Table of whole-frame vectors plus hand sequences for cfg_err, enable, abort and reset.
module tb_roi_pool_core;
   localparam int WIDTH     = 64;
   localparam int HEIGHT    = 40;
   localparam int PIX_W     = 4;
   localparam int OUT_PIX_W = 8;
   localparam int BLK_W     = 8;
   localparam int BLK_H     = 8;
   localparam int OUT_W     = 4;
   localparam int OUT_H     = 3;
   localparam int AW        = 4;
   localparam int NBLK      = OUT_W * OUT_H;
   localparam int RW        = BLK_W * OUT_W;
   localparam int RH        = BLK_H * OUT_H;

   localparam int P_CONST = 0;
   localparam int P_CYC   = 1;
   localparam int P_ALT   = 2;

   logic clk25 = 1'b0;
   logic rst_n = 1'b0;
   always #20 clk25 = ~clk25;

   roi_pool_core_if #(
      .PIX_W(PIX_W), .OUT_PIX_W(OUT_PIX_W), .AW(AW)
   ) bus ();

   roi_pool_core #(
      .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PIX_W(PIX_W),
      .OUT_PIX_W(OUT_PIX_W), .BLK_W(BLK_W), .BLK_H(BLK_H),
      .OUT_W(OUT_W), .OUT_H(OUT_H)
   ) dut (
      .clk25(clk25),
      .rst_n(rst_n),
      .io(bus)
   );

   typedef struct {
      int md;
      int th;
      int pat;
      int cval;
      int rx;
      int ry;
      int stall;
      int exp_e;
      int exp_o;
   } vec_t;

   vec_t vt[11];
   int   n_chk = 0;
   int   n_pass = 0;
   int   wr_addr[$];
   int   wr_data[$];
   int   fd_cnt = 0;
   bit   busy_seen;

   always @(negedge clk25) begin
      if (bus.out_we) begin
         wr_addr.push_back(int'(bus.out_addr));
         wr_data.push_back(int'(bus.out_data));
      end
      if (bus.frame_done)
         fd_cnt++;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   function automatic int pix_val(input int pat, input int cval,
                                  input int h, input int v,
                                  input int rx, input int ry);
      int lx;
      int ly;
      lx = h - rx;
      ly = v - ry;
      if (lx < 0 || ly < 0 || lx >= RW || ly >= RH)
         return (h * 3 + v) & 15;
      case (pat)
         P_CYC:   return ((lx % 8) + (ly % 8) * 8) % 16;
         P_ALT:   return ((lx / 8) % 2) ? 8 : 7;
         default: return cval;
      endcase
   endfunction

   task automatic idle(input int n);
      bus.pix_valid = 1'b0;
      bus.sof       = 1'b0;
      repeat (n) begin
         @(posedge clk25);
         #1;
      end
   endtask

   task automatic send_frame(input int rx, input int ry, input int md,
                             input int th, input int pat, input int cval,
                             input int en, input int stall,
                             input int stop_row);
      for (int v = 0; v < HEIGHT; v++) begin
         if (v == stop_row)
            break;
         for (int h = 0; h < WIDTH; h++) begin
            if (stall != 0) begin
               for (int k = 0; k < 4 && $urandom_range(0, 1) == 1; k++) begin
                  bus.pix_valid = 1'b0;
                  bus.sof       = 1'b0;
                  bus.pix_in    = PIX_W'($urandom_range(0, 15));
                  @(posedge clk25);
                  #1;
               end
            end
            bus.pix_valid = 1'b1;
            bus.sof       = (h == 0 && v == 0);
            bus.pix_in    = PIX_W'(pix_val(pat, cval, h, v, rx, ry));
            if (h == 0 && v == 0) begin
               bus.roi_x  = 10'(rx);
               bus.roi_y  = 10'(ry);
               bus.mode   = 2'(md);
               bus.thresh = OUT_PIX_W'(th);
               bus.enable = en[0];
            end
            @(posedge clk25);
            #1;
            if (h == 0 && v == 0) begin
               busy_seen  = bus.busy;
               bus.roi_x  = 10'($urandom_range(0, 1023));
               bus.roi_y  = 10'($urandom_range(0, 1023));
               bus.mode   = 2'($urandom_range(0, 3));
               bus.thresh = OUT_PIX_W'($urandom_range(0, 255));
               bus.enable = 1'($urandom_range(0, 1));
            end
         end
      end
      idle(4);
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      fd_cnt = 0;
   endtask

   task automatic check_frame(input string nm, input int exp_e,
                              input int exp_o);
      int n;
      chk({nm, " writes"}, wr_addr.size(), NBLK);
      chk({nm, " frame_done"}, fd_cnt, 1);
      chk({nm, " busy"}, int'(busy_seen), 1);
      n = (wr_addr.size() < NBLK) ? wr_addr.size() : NBLK;
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s addr%0d", nm, i), wr_addr[i], i);
         chk($sformatf("%s data%0d", nm, i), wr_data[i],
             ((i % OUT_W) % 2) ? exp_o : exp_e);
      end
   endtask

   initial begin
      vt[0]  = '{0, 0,     P_CONST, 10, 16, 8,  0, 'hAA, 'hAA};
      vt[1]  = '{0, 0,     P_CYC,   0,  16, 8,  0, 'h88, 'h88};
      vt[2]  = '{1, 0,     P_CYC,   0,  16, 8,  0, 'hFF, 'hFF};
      vt[3]  = '{2, 'h80,  P_ALT,   0,  16, 8,  0, 'h00, 'hFF};
      vt[4]  = '{3, 0,     P_CONST, 5,  16, 8,  0, 'h55, 'h55};
      vt[5]  = '{1, 0,     P_ALT,   0,  16, 8,  0, 'h77, 'h88};
      vt[6]  = '{0, 0,     P_CONST, 3,  32, 16, 0, 'h33, 'h33};
      vt[7]  = '{0, 0,     P_ALT,   0,  0,  0,  0, 'h77, 'h88};
      vt[8]  = '{2, 'h77,  P_ALT,   0,  16, 8,  0, 'hFF, 'hFF};
      vt[9]  = '{0, 0,     P_CONST, 10, 16, 8,  1, 'hAA, 'hAA};
      vt[10] = '{2, 'h78,  P_ALT,   0,  8,  4,  1, 'h00, 'hFF};

      bus.pix_in    = '0;
      bus.pix_valid = 1'b0;
      bus.sof       = 1'b0;
      bus.enable    = 1'b0;
      bus.mode      = '0;
      bus.thresh    = '0;
      bus.roi_x     = '0;
      bus.roi_y     = '0;

      #50;
      chk("rst out_we", int'(bus.out_we), 0);
      chk("rst out_addr", int'(bus.out_addr), 0);
      chk("rst out_data", int'(bus.out_data), 0);
      chk("rst frame_done", int'(bus.frame_done), 0);
      chk("rst busy", int'(bus.busy), 0);
      chk("rst cfg_err", int'(bus.cfg_err), 0);
      @(posedge clk25);
      #1;
      rst_n = 1'b1;
      idle(3);

      for (int i = 0; i < 11; i++) begin
         clear_log();
         send_frame(vt[i].rx, vt[i].ry, vt[i].md, vt[i].th,
                    vt[i].pat, vt[i].cval, 1, vt[i].stall, -1);
         check_frame($sformatf("vec%0d", i), vt[i].exp_e, vt[i].exp_o);
      end

      // ROI that overruns the frame on the right
      clear_log();
      send_frame(33, 0, 0, 0, P_CONST, 5, 1, 0, -1);
      chk("err cfg_err", int'(bus.cfg_err), 1);
      chk("err busy_at_sof", int'(busy_seen), 0);
      chk("err busy", int'(bus.busy), 0);
      chk("err writes", wr_addr.size(), 0);
      chk("err frame_done", fd_cnt, 0);

      clear_log();
      send_frame(0, 0, 0, 0, P_CONST, 5, 1, 0, -1);
      chk("clr cfg_err", int'(bus.cfg_err), 0);
      check_frame("clr", 'h55, 'h55);

      // ROI that overruns the frame at the bottom
      clear_log();
      send_frame(0, 17, 0, 0, P_CONST, 5, 1, 0, -1);
      chk("erry cfg_err", int'(bus.cfg_err), 1);
      chk("erry writes", wr_addr.size(), 0);

      // Disabled frame
      clear_log();
      send_frame(16, 8, 0, 0, P_CONST, 5, 0, 0, -1);
      chk("dis cfg_err", int'(bus.cfg_err), 0);
      chk("dis busy_at_sof", int'(busy_seen), 0);
      chk("dis writes", wr_addr.size(), 0);
      chk("dis frame_done", fd_cnt, 0);

      // Abort at row 20: only block row 0 (rows 8..15) has completed
      clear_log();
      send_frame(16, 8, 0, 0, P_CONST, 10, 1, 0, 20);
      chk("abort busy", int'(bus.busy), 1);
      chk("abort partial writes", wr_addr.size(), OUT_W);
      wr_addr.delete();
      wr_data.delete();
      send_frame(16, 8, 0, 0, P_CONST, 3, 1, 0, -1);
      check_frame("restart", 'h33, 'h33);

      // Asynchronous reset mid-frame
      clear_log();
      send_frame(16, 8, 0, 0, P_CONST, 10, 1, 0, 20);
      chk("mid busy", int'(bus.busy), 1);
      rst_n = 1'b0;
      #1;
      chk("mrst busy", int'(bus.busy), 0);
      chk("mrst out_addr", int'(bus.out_addr), 0);
      chk("mrst out_data", int'(bus.out_data), 0);
      @(posedge clk25);
      #1;
      rst_n = 1'b1;
      clear_log();
      bus.sof = 1'b0;
      for (int k = 0; k < 1200; k++) begin
         bus.pix_valid = 1'b1;
         bus.pix_in    = 4'hA;
         @(posedge clk25);
         #1;
      end
      idle(4);
      chk("mrst writes", wr_addr.size(), 0);
      chk("mrst frame_done", fd_cnt, 0);
      chk("mrst busy after", int'(bus.busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
